jpeg_mcu_scheduler: RTL and testbench
=====================================

Name: jpeg_mcu_scheduler

Overview:
- Sequences entropy-coded-segment decoding after the SOS header, one 8x8 block at a time.
- Walks MCUs in raster order, components in scan order, and blocks in each component's HxV raster.
- For each block, issues a command with component id, DC/AC Huffman table ids and quant table id to the Huffman block decoder, then waits for that block to finish.
- Handles restart intervals (DRI) and flags when DC predictors must be reset.

Parameters:
- MAX_COMP, 4, maximum components per scan.
- MAX_SAMP, 2, maximum H or V sampling factor.
- DIM_W, 16, width of the MCU-count and restart-interval fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; latches config and begins a scan (ignored unless IDLE)
- cfg_num_comp  in  3  components in scan, 1..MAX_COMP
- cfg_samp_hv  in  MAX_COMP*4  per component {H[1:0],V[1:0]}, comp0 in LSBs
- cfg_dc_tbl  in  MAX_COMP*2  DC Huffman table id per component
- cfg_ac_tbl  in  MAX_COMP*2  AC Huffman table id per component
- cfg_qt  in  MAX_COMP*2  quant table id per component
- cfg_mcus_x  in  DIM_W  MCUs per row
- cfg_mcus_y  in  DIM_W  MCU rows
- cfg_restart_int  in  DIM_W  MCUs per restart interval; 0 = none
- blk_valid  out  1  block command valid
- blk_ready  in  1  decoder accepts command
- blk_comp  out  2  component index
- blk_h, blk_v  out  2 each  block position within component
- blk_dc_tbl, blk_ac_tbl, blk_qt  out  2 each  table ids
- blk_pred_reset  out  1  reset this component's DC predictor before decoding
- blk_done  in  1  pulse; decoder finished the accepted block
- rst_req  out  1  request RSTn marker consume
- rst_ack  in  1  marker consumed
- mcu_x, mcu_y  out  DIM_W each  current MCU position
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at scan end
- err  out  1  sticky config error; cleared by next start

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States: IDLE, CHECK, ISSUE, WAIT_DONE, RESTART, DONE, ERR.
- IDLE: on start, register config, clear err, go to CHECK.
- CHECK (1 cycle) validates:
  - num_comp in 1..MAX_COMP;
  - every used H,V in 1..MAX_SAMP;
  - mcus_x and mcus_y nonzero;
  - if num_comp>1, sum of H*V <= 10.
  - Fail: ERR (err=1, go to IDLE next cycle). Pass: ISSUE.
- blk_valid is asserted 2 cycles after start is sampled.
- Non-interleaved scan (num_comp=1): each MCU is one block; H/V ignored; blk_h=blk_v=0.
- ISSUE: blk_valid=1; payload stable while blk_valid && !blk_ready. On handshake, go to WAIT_DONE with blk_valid=0.
- One command outstanding at a time. blk_done outside WAIT_DONE is ignored.
- WAIT_DONE, on blk_done, advance in this order:
  - blk_h, then blk_v;
  - then component;
  - then MCU: mcu_x wraps at mcus_x-1 to 0 and increments mcu_y.
- At the last block of the last MCU: go to DONE (done=1 for one cycle), then IDLE.
- Restart:
  - The interval counter increments per completed MCU.
  - When it equals cfg_restart_int (nonzero) and the MCU was not the last: go to RESTART, rst_req=1 until rst_ack, clear the counter, then ISSUE.
  - rst_ack outside RESTART is ignored. No rst_req after the final MCU.
- blk_pred_reset=1 on the first block of each component after scan start and after each restart; 0 otherwise.
- Simultaneous start and anything while busy: start ignored.
- Reset mid-scan: immediate return to IDLE, outputs 0, no done.

Optional Feature:
- JPEG_DRI_EN defined: restart handling as above.
- Undefined: cfg_restart_int ignored, RESTART state absent, rst_req tied 0, blk_pred_reset only at scan start.

Decomposition:
- jpeg_pkg holds:
  - state enum sched_state_t;
  - struct comp_cfg_t {h, v, dc_tbl, ac_tbl, qt};
  - constant MAX_BLOCKS_PER_MCU=10.
- Sub-module jpeg_mcu_block_iter holds the h/v/component counters. It exposes step, last_blk_in_mcu and current indices; the scheduler owns the MCU and interval counters and the FSM.

Test Plan:
- Grayscale: num_comp=1, mcus 2x1, restart 0 -> 2 commands comp0 (0,0), pred_reset=1 then 0; done 1 cycle after second blk_done.
- 4:2:0: Y 2x2, Cb/Cr 1x1, dc/ac ids 0,1,1, 1x1 MCU -> 6 commands: comp0 (0,0),(1,0),(0,1),(1,1), comp1, comp2, tables matching.
- Restart: 1 comp, mcus 3x1, restart_int 2 -> rst_req after 2nd blk_done, held until rst_ack 3 cycles later; 3rd block pred_reset=1; no rst_req at end.
- Config error: 3 comps all 2x2 (12 blocks) -> err=1, blk_valid never asserted, busy clears 2 cycles after start.
- Backpressure: blk_ready low 5 cycles -> payload stable; spurious blk_done during ISSUE ignored; start while busy ignored.
- rst_n asserted during WAIT_DONE -> all outputs 0 immediately; a new start restarts at MCU (0,0).

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG MCU scheduler slice.
package jpeg_pkg;

  localparam int unsigned MAX_BLOCKS_PER_MCU = 10;

  // Legacy state encodings, kept so existing tooling/waveform decoders still match.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHECK     = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESTART   = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_ERR       = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_CHECK     = ST_CHECK,
    S_ISSUE     = ST_ISSUE,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_RESTART   = ST_RESTART,
    S_DONE      = ST_DONE,
    S_ERR       = ST_ERR
  } sched_state_t;

  typedef struct packed {
    logic [1:0] h;
    logic [1:0] v;
    logic [1:0] dc_tbl;
    logic [1:0] ac_tbl;
    logic [1:0] qt;
  } comp_cfg_t;

  // Blocks contributed by one component to an interleaved MCU (max 3*3).
  function automatic logic [3:0] samp_blocks(input logic [1:0] h, input logic [1:0] v);
    return {2'b00, h} * {2'b00, v};
  endfunction

endpackage

// File: rtl/jpeg_mcu_block_iter.sv
// Block iterator inside one MCU: h, then v, then component.
import jpeg_pkg::*;

module jpeg_mcu_block_iter #(
  parameter int unsigned MAX_COMP = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      step,
  input  logic                      interleaved,
  input  logic [2:0]                num_comp,
  input  logic [MAX_COMP-1:0][1:0]  samp_h,
  input  logic [MAX_COMP-1:0][1:0]  samp_v,
  output logic [1:0]                comp,
  output logic [1:0]                h,
  output logic [1:0]                v,
  output logic                      last_blk_in_mcu
);

  logic [1:0] h_lim;
  logic [1:0] v_lim;
  logic       last_h;
  logic       last_v;
  logic       last_comp;

  // Non-interleaved scans have exactly one block per MCU regardless of H/V.
  always_comb begin
    h_lim           = interleaved ? samp_h[comp] - 2'd1 : 2'd0;
    v_lim           = interleaved ? samp_v[comp] - 2'd1 : 2'd0;
    last_h          = (h == h_lim);
    last_v          = (v == v_lim);
    last_comp       = ({1'b0, comp} == num_comp - 3'd1);
    last_blk_in_mcu = last_h && last_v && last_comp;
  end

  // Advance indices on each completed block; wrap to the MCU's first block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp <= '0;
      h    <= '0;
      v    <= '0;
    end else if (clear) begin
      comp <= '0;
      h    <= '0;
      v    <= '0;
    end else if (step) begin
      if (!last_h) begin
        h <= h + 2'd1;
      end else begin
        h <= '0;
        if (!last_v) begin
          v <= v + 2'd1;
        end else begin
          v    <= '0;
          comp <= last_comp ? 2'd0 : comp + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/jpeg_mcu_scheduler.sv
// Scan scheduler: walks MCUs/components/blocks and issues block decode commands.
// Optional restart-interval handling is enabled by defining JPEG_DRI_EN.
import jpeg_pkg::*;

module jpeg_mcu_scheduler #(
  parameter int unsigned MAX_COMP = 4,
  parameter int unsigned MAX_SAMP = 2,
  parameter int unsigned DIM_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            cfg_num_comp,
  input  logic [MAX_COMP*4-1:0] cfg_samp_hv,
  input  logic [MAX_COMP*2-1:0] cfg_dc_tbl,
  input  logic [MAX_COMP*2-1:0] cfg_ac_tbl,
  input  logic [MAX_COMP*2-1:0] cfg_qt,
  input  logic [DIM_W-1:0]      cfg_mcus_x,
  input  logic [DIM_W-1:0]      cfg_mcus_y,
  input  logic [DIM_W-1:0]      cfg_restart_int,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [1:0]            blk_comp,
  output logic [1:0]            blk_h,
  output logic [1:0]            blk_v,
  output logic [1:0]            blk_dc_tbl,
  output logic [1:0]            blk_ac_tbl,
  output logic [1:0]            blk_qt,
  output logic                  blk_pred_reset,
  input  logic                  blk_done,
  output logic                  rst_req,
  input  logic                  rst_ack,
  output logic [DIM_W-1:0]      mcu_x,
  output logic [DIM_W-1:0]      mcu_y,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  sched_state_t                state;
  comp_cfg_t [MAX_COMP-1:0]    cfg_in;
  comp_cfg_t [MAX_COMP-1:0]    cfg_r;
  logic [2:0]                  num_comp_r;
  logic [DIM_W-1:0]            mcus_x_r;
  logic [DIM_W-1:0]            mcus_y_r;
  logic [MAX_COMP-1:0]         pred_pend;
  logic [MAX_COMP-1:0][1:0]    samp_h;
  logic [MAX_COMP-1:0][1:0]    samp_v;
  logic [5:0]                  blk_sum;
  logic                        cfg_ok;
  logic                        last_blk;
  logic                        last_mcu;
  logic                        last_x;
  logic                        iter_step;
  logic                        iter_clear;

`ifdef JPEG_DRI_EN
  logic [DIM_W-1:0]            restart_r;
  logic [DIM_W-1:0]            int_cnt;
`else
  logic                        unused_dri;
  assign unused_dri = ^{cfg_restart_int, rst_ack};
`endif

  // Unpack the flat configuration buses into per-component records.
  always_comb begin
    cfg_in = '0;
    samp_h = '0;
    samp_v = '0;
    for (int unsigned i = 0; i < MAX_COMP; i++) begin
      cfg_in[i].h      = cfg_samp_hv[4*i+2 +: 2];
      cfg_in[i].v      = cfg_samp_hv[4*i   +: 2];
      cfg_in[i].dc_tbl = cfg_dc_tbl[2*i +: 2];
      cfg_in[i].ac_tbl = cfg_ac_tbl[2*i +: 2];
      cfg_in[i].qt     = cfg_qt[2*i +: 2];
      samp_h[i]        = cfg_r[i].h;
      samp_v[i]        = cfg_r[i].v;
    end
  end

  // Validate the latched configuration; H/V only matter for interleaved scans.
  always_comb begin
    cfg_ok  = 1'b1;
    blk_sum = '0;
    if (num_comp_r == 3'd0 || num_comp_r > 3'(MAX_COMP)) cfg_ok = 1'b0;
    if (mcus_x_r == '0 || mcus_y_r == '0) cfg_ok = 1'b0;
    if (num_comp_r > 3'd1) begin
      for (int unsigned i = 0; i < MAX_COMP; i++) begin
        if (3'(i) < num_comp_r) begin
          if (cfg_r[i].h == 2'd0 || cfg_r[i].h > 2'(MAX_SAMP)) cfg_ok = 1'b0;
          if (cfg_r[i].v == 2'd0 || cfg_r[i].v > 2'(MAX_SAMP)) cfg_ok = 1'b0;
          blk_sum = blk_sum + {2'b00, samp_blocks(cfg_r[i].h, cfg_r[i].v)};
        end
      end
      if (blk_sum > 6'(MAX_BLOCKS_PER_MCU)) cfg_ok = 1'b0;
    end
  end

  assign iter_clear = (state == S_IDLE) && start;
  assign iter_step  = (state == S_WAIT_DONE) && blk_done;
  assign last_x     = (mcu_x == mcus_x_r - DIM_ONE);
  assign last_mcu   = last_x && (mcu_y == mcus_y_r - DIM_ONE);

  jpeg_mcu_block_iter #(
    .MAX_COMP (MAX_COMP)
  ) u_iter (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (iter_clear),
    .step            (iter_step),
    .interleaved     (num_comp_r > 3'd1),
    .num_comp        (num_comp_r),
    .samp_h          (samp_h),
    .samp_v          (samp_v),
    .comp            (blk_comp),
    .h               (blk_h),
    .v               (blk_v),
    .last_blk_in_mcu (last_blk)
  );

  // Scan FSM plus MCU position, restart interval and predictor-reset tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      err        <= 1'b0;
      cfg_r      <= '0;
      num_comp_r <= '0;
      mcus_x_r   <= '0;
      mcus_y_r   <= '0;
      mcu_x      <= '0;
      mcu_y      <= '0;
      pred_pend  <= '0;
`ifdef JPEG_DRI_EN
      restart_r  <= '0;
      int_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_r      <= cfg_in;
            num_comp_r <= cfg_num_comp;
            mcus_x_r   <= cfg_mcus_x;
            mcus_y_r   <= cfg_mcus_y;
            mcu_x      <= '0;
            mcu_y      <= '0;
            err        <= 1'b0;
`ifdef JPEG_DRI_EN
            restart_r  <= cfg_restart_int;
            int_cnt    <= '0;
`endif
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cfg_ok) begin
            pred_pend <= '1;
            state     <= S_ISSUE;
          end else begin
            err   <= 1'b1;
            state <= S_ERR;
          end
        end
        S_ISSUE: begin
          if (blk_ready) begin
            pred_pend[blk_comp] <= 1'b0;
            state               <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (blk_done) begin
            if (!last_blk) begin
              state <= S_ISSUE;
            end else if (last_mcu) begin
              state <= S_DONE;
            end else begin
              if (last_x) begin
                mcu_x <= '0;
                mcu_y <= mcu_y + DIM_ONE;
              end else begin
                mcu_x <= mcu_x + DIM_ONE;
              end
`ifdef JPEG_DRI_EN
              // Interval count compares the post-increment value so the
              // marker is requested right after the Nth MCU completes.
              if (restart_r != '0 && int_cnt + DIM_ONE == restart_r) begin
                int_cnt <= '0;
                state   <= S_RESTART;
              end else begin
                int_cnt <= int_cnt + DIM_ONE;
                state   <= S_ISSUE;
              end
`else
              state <= S_ISSUE;
`endif
            end
          end
        end
`ifdef JPEG_DRI_EN
        S_RESTART: begin
          if (rst_ack) begin
            pred_pend <= '1;
            state     <= S_ISSUE;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign blk_valid      = (state == S_ISSUE);
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign blk_dc_tbl     = cfg_r[blk_comp].dc_tbl;
  assign blk_ac_tbl     = cfg_r[blk_comp].ac_tbl;
  assign blk_qt         = cfg_r[blk_comp].qt;
  assign blk_pred_reset = pred_pend[blk_comp];
`ifdef JPEG_DRI_EN
  assign rst_req        = (state == S_RESTART);
`else
  assign rst_req        = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// Scoreboard bench for jpeg_mcu_scheduler: stimulus queues expected commands,
// a negedge monitor pops and compares on each accepted command.
module tb_jpeg_mcu_scheduler;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  comp;
    logic [1:0]  h;
    logic [1:0]  v;
    logic [1:0]  dc;
    logic [1:0]  ac;
    logic [1:0]  qt;
    logic        pred;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cfg_num_comp = '0;
  logic [15:0] cfg_samp_hv = '0;
  logic [7:0]  cfg_dc_tbl = '0;
  logic [7:0]  cfg_ac_tbl = '0;
  logic [7:0]  cfg_qt = '0;
  logic [15:0] cfg_mcus_x = '0;
  logic [15:0] cfg_mcus_y = '0;
  logic [15:0] cfg_restart_int = '0;
  logic        blk_ready = 1'b0;
  logic        blk_done = 1'b0;
  logic        rst_ack = 1'b0;
  logic        blk_valid, blk_pred_reset, rst_req, busy, done, err;
  logic [1:0]  blk_comp, blk_h, blk_v, blk_dc_tbl, blk_ac_tbl, blk_qt;
  logic [15:0] mcu_x, mcu_y;

  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  cmd_t exp_q[$];
  cmd_t mon_act;
  cmd_t mon_exp;
  logic [49:0] all_out;

  always #5 clk = ~clk;

  jpeg_mcu_scheduler #(
    .MAX_COMP (4),
    .MAX_SAMP (2),
    .DIM_W    (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .cfg_num_comp    (cfg_num_comp),
    .cfg_samp_hv     (cfg_samp_hv),
    .cfg_dc_tbl      (cfg_dc_tbl),
    .cfg_ac_tbl      (cfg_ac_tbl),
    .cfg_qt          (cfg_qt),
    .cfg_mcus_x      (cfg_mcus_x),
    .cfg_mcus_y      (cfg_mcus_y),
    .cfg_restart_int (cfg_restart_int),
    .blk_valid       (blk_valid),
    .blk_ready       (blk_ready),
    .blk_comp        (blk_comp),
    .blk_h           (blk_h),
    .blk_v           (blk_v),
    .blk_dc_tbl      (blk_dc_tbl),
    .blk_ac_tbl      (blk_ac_tbl),
    .blk_qt          (blk_qt),
    .blk_pred_reset  (blk_pred_reset),
    .blk_done        (blk_done),
    .rst_req         (rst_req),
    .rst_ack         (rst_ack),
    .mcu_x           (mcu_x),
    .mcu_y           (mcu_y),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  assign all_out = {blk_valid, blk_comp, blk_h, blk_v, blk_dc_tbl, blk_ac_tbl, blk_qt,
                    blk_pred_reset, rst_req, mcu_x, mcu_y, busy, done, err};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [1:0] c,
                      input logic [1:0] h, input logic [1:0] v, input logic [1:0] dc,
                      input logic [1:0] ac, input logic [1:0] qt, input logic p);
    cmd_t e;
    e = '{x: x, y: y, comp: c, h: h, v: v, dc: dc, ac: ac, qt: qt, pred: p};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!blk_valid && n < 50) begin
      tick();
      n++;
    end
    check(name, blk_valid, 1);
  endtask

  // Accept one command, then report completion after 'lat' cycles.
  task automatic do_block(input int lat);
    wait_valid("blk_valid_wait");
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    repeat (lat) tick();
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
  endtask

  task automatic set_cfg(input logic [2:0] n, input logic [15:0] hv, input logic [7:0] dc,
                         input logic [7:0] ac, input logic [7:0] qt, input logic [15:0] mx,
                         input logic [15:0] my, input logic [15:0] ri);
    cfg_num_comp    = n;
    cfg_samp_hv     = hv;
    cfg_dc_tbl      = dc;
    cfg_ac_tbl      = ac;
    cfg_qt          = qt;
    cfg_mcus_x      = mx;
    cfg_mcus_y      = my;
    cfg_restart_int = ri;
  endtask

  // Scoreboard monitor: compare every accepted command against the queue head.
  always @(negedge clk) begin
    if (rst_n && blk_valid && blk_ready) begin
      mon_act = '{x: mcu_x, y: mcu_y, comp: blk_comp, h: blk_h, v: blk_v, dc: blk_dc_tbl,
                  ac: blk_ac_tbl, qt: blk_qt, pred: blk_pred_reset};
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", {19'd0, mon_act}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("cmd", {19'd0, mon_act}, {19'd0, mon_exp});
      end
    end
    if (rst_n && done) done_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("reset_outs", all_out, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Grayscale, 2x1 MCUs
    set_cfg(3'd1, 16'h0005, 8'h02, 8'h03, 8'h01, 16'd2, 16'd1, 16'd0);
    push(0, 0, 0, 0, 0, 2, 3, 1, 1);
    push(1, 0, 0, 0, 0, 2, 3, 1, 0);
    pulse_start();
    check("gray_valid_1cyc", blk_valid, 0);
    check("gray_busy", busy, 1);
    tick();
    check("gray_valid_2cyc", blk_valid, 1);
    do_block(2);
    do_block(3);
    check("gray_done", done, 1);
    done_exp++;
    tick();
    check("gray_done_1cyc", done, 0);
    check("gray_idle", busy, 0);

    // 4:2:0 single MCU
    set_cfg(3'd3, 16'h055A, 8'h14, 8'h14, 8'h14, 16'd1, 16'd1, 16'd0);
    push(0, 0, 0, 0, 0, 0, 0, 0, 1);
    push(0, 0, 0, 1, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 1, 0, 0, 0, 0);
    push(0, 0, 0, 1, 1, 0, 0, 0, 0);
    push(0, 0, 1, 0, 0, 1, 1, 1, 1);
    push(0, 0, 2, 0, 0, 1, 1, 1, 1);
    pulse_start();
    for (int i = 0; i < 6; i++) do_block(1);
    check("420_done", done, 1);
    done_exp++;
    tick();

    // Restart interval 2 over 3 MCUs
    set_cfg(3'd1, 16'h0005, 8'h01, 8'h02, 8'h03, 16'd3, 16'd1, 16'd2);
    push(0, 0, 0, 0, 0, 1, 2, 3, 1);
    push(1, 0, 0, 0, 0, 1, 2, 3, 0);
`ifdef JPEG_DRI_EN
    push(2, 0, 0, 0, 0, 1, 2, 3, 1);
`else
    push(2, 0, 0, 0, 0, 1, 2, 3, 0);
`endif
    pulse_start();
    do_block(1);
    check("rst_req_early", rst_req, 0);
    do_block(1);
`ifdef JPEG_DRI_EN
    check("rst_req_set", rst_req, 1);
    check("rst_no_valid", blk_valid, 0);
    tick();
    check("rst_req_hold1", rst_req, 1);
    tick();
    check("rst_req_hold2", rst_req, 1);
    rst_ack = 1'b1;
    tick();
    rst_ack = 1'b0;
    check("rst_req_clear", rst_req, 0);
    check("rst_then_valid", blk_valid, 1);
`else
    check("rst_req_disabled", rst_req, 0);
`endif
    do_block(1);
    check("rst_done", done, 1);
    check("rst_req_final", rst_req, 0);
    done_exp++;
    tick();

    // Config error: 3 comps at 2x2 exceeds the block budget
    set_cfg(3'd3, 16'h0AAA, 8'h00, 8'h00, 8'h00, 16'd1, 16'd1, 16'd0);
    pulse_start();
    check("err_c0_err", err, 0);
    check("err_c0_busy", busy, 1);
    tick();
    check("err_c1_err", err, 1);
    check("err_c1_valid", blk_valid, 0);
    tick();
    check("err_c2_busy", busy, 0);
    check("err_sticky", err, 1);
    check("err_c2_valid", blk_valid, 0);

    // Config error: zero MCUs per row; start clears the previous err
    set_cfg(3'd1, 16'h0005, 8'h00, 8'h00, 8'h00, 16'd0, 16'd1, 16'd0);
    pulse_start();
    check("err_cleared_by_start", err, 0);
    tick();
    check("err_zero_mcus", err, 1);
    tick();

    // Backpressure, spurious blk_done and start while busy
    set_cfg(3'd1, 16'h0005, 8'h03, 8'h01, 8'h02, 16'd1, 16'd1, 16'd0);
    push(0, 0, 0, 0, 0, 3, 1, 2, 1);
    pulse_start();
    check("bp_err_clear", err, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_payload", {blk_valid, blk_comp, blk_h, blk_v, blk_dc_tbl, blk_ac_tbl, blk_qt, blk_pred_reset},
            {1'b1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd2, 1'b1});
      blk_done = (i == 1);
      start    = (i == 3);
      if (i == 3) set_cfg(3'd3, 16'h055A, 8'hFF, 8'hFF, 8'hFF, 16'd4, 16'd4, 16'd0);
      tick();
    end
    blk_done = 1'b0;
    start    = 1'b0;
    do_block(2);
    check("bp_done", done, 1);
    done_exp++;
    tick();
    tick();
    check("bp_start_ignored", busy, 0);

    // Async reset during WAIT_DONE, then a fresh 2x2 grayscale scan
    set_cfg(3'd3, 16'h055A, 8'h14, 8'h14, 8'h14, 16'd1, 16'd1, 16'd0);
    push(0, 0, 0, 0, 0, 0, 0, 0, 1);
    pulse_start();
    wait_valid("mid_valid");
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("reset_mid_outs", all_out, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    set_cfg(3'd1, 16'h0005, 8'h01, 8'h01, 8'h00, 16'd2, 16'd2, 16'd0);
    push(0, 0, 0, 0, 0, 1, 1, 0, 1);
    push(1, 0, 0, 0, 0, 1, 1, 0, 0);
    push(0, 1, 0, 0, 0, 1, 1, 0, 0);
    push(1, 1, 0, 0, 0, 1, 1, 0, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) do_block(1);
    check("post_reset_done", done, 1);
    done_exp++;
    tick();
    tick();

    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_seen, done_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
